// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the Wishbone interconnect: FSM states and the
// slave select indices of the channel and clock blocks.
package wb_intercon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2,
        ST_DONE   = 2'd3
    } wb_state_e;

    localparam int SL_CH1  = 0;
    localparam int SL_CH2  = 1;
    localparam int SL_CH3  = 2;
    localparam int SL_CH4  = 3;
    localparam int SL_CH5  = 4;
    localparam int SL_CH6  = 5;
    localparam int SL_CH7  = 6;
    localparam int SL_CH8  = 7;
    localparam int SL_CLKA = 8;
    localparam int SL_CLKB = 9;
    localparam int SL_CLKC = 10;
    localparam int SL_CLKD = 11;

    function automatic logic is_mapped(input int sel, input int num_slaves);
        return sel < num_slaves;
    endfunction

endpackage

// File: rtl/wb_intercon_watchdog.sv
// No-ack watchdog: counts enabled cycles from zero and flags the cycle
// in which the count reaches TIMEOUT-1.
module wb_watchdog #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    assign expire_o = en_i && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_intercon.sv
// Single-master, N-slave Wishbone interconnect with registered strobe,
// data and ack paths, a no-ack watchdog and error capture.
module wb_intercon
    import wb_intercon_pkg::*;
#(
    parameter int NUM_SLAVES = 12,
    parameter int ADR_W      = 8,
    parameter int SEL_W      = 4,
    parameter int DAT_W      = 8,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8,
    parameter int ECNT_W     = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        m_stb_i,
    input  logic                        m_we_i,
    input  logic [ADR_W-1:0]            m_adr_i,
    input  logic [DAT_W-1:0]            m_dat_i,
    output logic [DAT_W-1:0]            m_dat_o,
    output logic                        m_ack_o,
    output logic                        m_err_o,
    output logic [NUM_SLAVES-1:0]       s_stb_o,
    output logic                        s_we_o,
    output logic [ADR_W-SEL_W-1:0]      s_adr_o,
    output logic [DAT_W-1:0]            s_dat_o,
    input  logic [NUM_SLAVES*DAT_W-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]       s_ack_i,
    input  logic                        err_clr_i,
    output logic [ECNT_W-1:0]           err_cnt_o,
    output logic [ADR_W-1:0]            err_adr_o
);

    wb_state_e             state_q;
    logic [SEL_W-1:0]      sel_q;
    logic [ADR_W-1:0]      adr_q;
    logic                  we_q;
    logic [DAT_W-1:0]      wdat_q;
    logic [DAT_W-1:0]      rdat_q;
    logic                  ack_q;
    logic                  err_q;
    logic [NUM_SLAVES-1:0] stb_q;
    logic [ECNT_W-1:0]     ecnt_q;
    logic [ECNT_W-1:0]     ecnt_d;
    logic [ADR_W-1:0]      eadr_q;

    logic [SEL_W-1:0] req_sel;
    logic             req_ok;
    logic             sel_ok;
    logic             ack_sel;
    logic             wd_exp;
    logic             active;
    logic             err_evt;
    logic [DAT_W-1:0] rd_sel;

    assign req_sel = m_adr_i[ADR_W-1 -: SEL_W];
    assign req_ok  = is_mapped(int'(req_sel), NUM_SLAVES);
    assign sel_ok  = is_mapped(int'(sel_q), NUM_SLAVES);
    assign ack_sel = sel_ok && s_ack_i[sel_q];
    assign rd_sel  = s_dat_i[int'(sel_q)*DAT_W +: DAT_W];
    assign active  = (state_q == ST_ACTIVE);

    // An abandoned transfer never reports an error.
    assign err_evt = active && m_stb_i &&
                     (!sel_ok || (!ack_sel && wd_exp));

    wb_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (!active),
        .en_i     (active),
        .expire_o (wd_exp)
    );

    always_comb begin
        ecnt_d = ecnt_q;
        if (err_clr_i) begin
            ecnt_d = err_evt ? ECNT_W'(1) : '0;
        end else if (err_evt && (ecnt_q != '1)) begin
            ecnt_d = ecnt_q + ECNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            stb_q   <= '0;
            ecnt_q  <= '0;
            eadr_q  <= '0;
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            ecnt_q <= ecnt_d;
            if (err_evt) begin
                eadr_q <= adr_q;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (m_stb_i) begin
                        sel_q   <= req_sel;
                        adr_q   <= m_adr_i;
                        we_q    <= m_we_i;
                        wdat_q  <= m_dat_i;
                        state_q <= ST_ACTIVE;
                        if (req_ok) begin
                            stb_q <= NUM_SLAVES'(1) << req_sel;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!m_stb_i) begin
                        stb_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (!sel_ok) begin
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else if (ack_sel) begin
                        stb_q   <= '0;
                        ack_q   <= 1'b1;
                        rdat_q  <= we_q ? '0 : rd_sel;
                        state_q <= ST_RESP;
                    end else if (wd_exp) begin
                        stb_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (!m_stb_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_dat_o   = rdat_q;
    assign m_ack_o   = ack_q;
    assign m_err_o   = err_q;
    assign s_stb_o   = stb_q;
    assign s_we_o    = we_q;
    assign s_adr_o   = adr_q[ADR_W-SEL_W-1:0];
    assign s_dat_o   = wdat_q;
    assign err_cnt_o = ecnt_q;
    assign err_adr_o = eadr_q;

endmodule

// File: tb/tb_wb_intercon.sv
// Bench for wb_intercon: cycle-indexed expectation tables built from the
// transaction rules, plus a short-timeout instance for the watchdog case.
module tb_wb_intercon;

    localparam int NS = 12;
    localparam int TO = 255;
    localparam int N  = 4096;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              m_stb_i = 1'b0;
    logic              m_we_i = 1'b0;
    logic [7:0]        m_adr_i = '0;
    logic [7:0]        m_dat_i = '0;
    logic [NS*8-1:0]   s_dat_i = '0;
    logic [NS-1:0]     s_ack_i = '0;
    logic              err_clr_i = 1'b0;

    logic [7:0]    m_dat_o, s_dat_o, err_cnt_o, err_adr_o;
    logic          m_ack_o, m_err_o, s_we_o;
    logic [NS-1:0] s_stb_o;
    logic [3:0]    s_adr_o;

    logic [7:0]    m_dat4, s_dat4, ecnt4, eadr4;
    logic          m_ack4, m_err4, s_we4;
    logic [NS-1:0] s_stb4;
    logic [3:0]    s_adr4;

    wb_intercon dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .err_clr_i(err_clr_i),
        .err_cnt_o(err_cnt_o), .err_adr_o(err_adr_o)
    );

    wb_intercon #(.TIMEOUT(4)) dut4 (
        .clk_i(clk), .rst_i(rst_i),
        .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat4), .m_ack_o(m_ack4), .m_err_o(m_err4),
        .s_stb_o(s_stb4), .s_we_o(s_we4),
        .s_adr_o(s_adr4), .s_dat_o(s_dat4),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .err_clr_i(err_clr_i),
        .err_cnt_o(ecnt4), .err_adr_o(eadr4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, passed = 0;
    int n_ack = 0, n_err = 0;
    bit chk_on = 0, d4_on = 0;
    int d4_stb = 0, d4_err = 0, d4_ack = 0, d4_err_cyc = 0;

    logic          exp_ack [N];
    logic          exp_err [N];
    logic          exp_lat [N];
    logic          exp_we  [N];
    logic [NS-1:0] exp_stb [N];
    logic [7:0]    exp_dat [N];
    logic [7:0]    exp_cnt [N];
    logic [7:0]    exp_eadr[N];
    logic [3:0]    exp_sadr[N];
    logic [7:0]    exp_sdat[N];

    int         m_cnt = 0;
    logic [7:0] m_adr = '0;

    logic [7:0] snap_mdat, snap_sdat;
    logic [3:0] snap_sadr;
    logic       snap_we;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc %0d: got %0h expected %0h",
                      nm, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_on && cyc < N) begin
            chk("m_ack", 32'(m_ack_o), 32'(exp_ack[cyc]));
            chk("m_err", 32'(m_err_o), 32'(exp_err[cyc]));
            chk("s_stb", 32'(s_stb_o), 32'(exp_stb[cyc]));
            chk("err_cnt", 32'(err_cnt_o), 32'(exp_cnt[cyc]));
            chk("err_adr", 32'(err_adr_o), 32'(exp_eadr[cyc]));
            if (exp_ack[cyc]) chk("m_dat", 32'(m_dat_o), 32'(exp_dat[cyc]));
            if (exp_lat[cyc]) begin
                chk("s_we", 32'(s_we_o), 32'(exp_we[cyc]));
                chk("s_adr", 32'(s_adr_o), 32'(exp_sadr[cyc]));
                chk("s_dat", 32'(s_dat_o), 32'(exp_sdat[cyc]));
            end
            if (m_ack_o) n_ack++;
            if (m_err_o) n_err++;
        end
        if (d4_on) begin
            if (s_stb4 != '0) begin
                d4_stb++;
                chk("d4_stb", 32'(s_stb4), 32'h001);
                chk("d4_sadr", 32'(s_adr4), 32'h7);
                chk("d4_swe", 32'(s_we4), 32'h0);
                chk("d4_sdat", 32'(s_dat4), 32'h0);
            end
            if (m_err4) begin
                d4_err++;
                d4_err_cyc = cyc;
            end
            if (m_ack4) d4_ack++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_from(input int c, input int cnt, input logic [7:0] a);
        for (int i = c; i < N; i++) begin
            exp_cnt[i]  = 8'(cnt);
            exp_eadr[i] = a;
        end
    endtask

    function automatic logic [NS*8-1:0] rdbus(input int sel,
                                              input logic [7:0] rd);
        logic [NS*8-1:0] v;
        for (int k = 0; k < NS; k++)
            v[k*8 +: 8] = (k == sel) ? rd : 8'(8'h3C + k);
        return v;
    endfunction

    task automatic set_lat(input int c, input int sel, input logic we,
                           input logic [3:0] off, input logic [7:0] wd);
        exp_stb[c]  = (sel < 0) ? '0 : NS'(1) << sel;
        exp_lat[c]  = 1'b1;
        exp_we[c]   = we;
        exp_sadr[c] = off;
        exp_sdat[c] = wd;
    endtask

    // dly: slave acks dly cycles after its strobe appears (-1: never).
    task automatic txn(input logic [7:0] adr, input logic we,
                       input logic [7:0] wd, input int dly,
                       input logic [7:0] rd, input int hold, input bit clr);
        int c0, r, last, sel, nz;
        bit is_err;
        step();
        c0 = cyc;
        sel = int'(adr[7:4]);
        m_stb_i = 1'b1; m_we_i = we; m_adr_i = adr; m_dat_i = wd;
        s_dat_i = rdbus(sel, rd);
        nz = (sel == 0) ? 1 : sel - 1;
        if (sel >= NS) begin
            last = c0; r = c0 + 2; is_err = 1;
        end else if (dly >= 0 && dly < TO) begin
            last = c0 + 1 + dly; r = last + 1; is_err = 0;
        end else begin
            last = c0 + TO; r = last + 1; is_err = 1;
        end
        for (int c = c0 + 1; c <= last; c++)
            set_lat(c, sel, we, adr[3:0], wd);
        if (is_err) begin
            exp_err[r] = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
            m_adr = adr;
            set_from(r, m_cnt, m_adr);
        end else begin
            exp_ack[r] = 1'b1;
            exp_dat[r] = we ? 8'h00 : rd;
        end
        for (int c = c0; c <= r + hold; c++) begin
            if (c != c0) step();
            s_ack_i = '0;
            if (sel < NS && c > c0 && c <= last) s_ack_i[nz] = 1'b1;
            if (sel < NS && dly >= 0 && c == c0 + 1 + dly) s_ack_i[sel] = 1'b1;
            err_clr_i = clr && (c == r - 1);
            if (c == c0 + 1) begin
                snap_we = s_we_o; snap_sadr = s_adr_o; snap_sdat = s_dat_o;
            end
            if (c == r) snap_mdat = m_dat_o;
        end
        step();
        m_stb_i = 1'b0; s_ack_i = '0; err_clr_i = 1'b0;
    endtask

    task automatic abandon(input logic [7:0] adr, input int k);
        int c0, sel;
        step();
        c0 = cyc;
        sel = int'(adr[7:4]);
        m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = adr; m_dat_i = 8'h00;
        for (int c = c0 + 1; c <= c0 + k + 1; c++)
            set_lat(c, sel, 1'b0, adr[3:0], 8'h00);
        repeat (k + 1) step();
        m_stb_i = 1'b0;
        step();
    endtask

    task automatic rst_test(input logic [7:0] adr, input int k);
        int c0, sel;
        step();
        c0 = cyc;
        sel = int'(adr[7:4]);
        m_stb_i = 1'b1; m_we_i = 1'b1; m_adr_i = adr; m_dat_i = 8'h9E;
        s_dat_i = rdbus(sel, 8'h11);
        for (int c = c0 + 1; c <= c0 + 1 + k; c++)
            set_lat(c, sel, 1'b1, adr[3:0], 8'h9E);
        for (int c = c0 + 2 + k; c <= c0 + 3 + k; c++)
            set_lat(c, -1, 1'b0, 4'h0, 8'h00);
        m_cnt = 0; m_adr = '0;
        set_from(c0 + 2 + k, 0, 8'h00);
        repeat (k + 1) step();
        rst_i = 1'b1; m_stb_i = 1'b0;
        s_ack_i = '0; s_ack_i[sel] = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        step();
        s_ack_i = '0;
    endtask

    task automatic do_clr();
        step();
        err_clr_i = 1'b1;
        m_cnt = 0;
        set_from(cyc + 1, 0, m_adr);
        step();
        err_clr_i = 1'b0;
    endtask

    int a0, e0, t3c0;

    initial begin
        for (int i = 0; i < N; i++) begin
            exp_ack[i] = 0; exp_err[i] = 0; exp_lat[i] = 0; exp_we[i] = 0;
            exp_stb[i] = '0; exp_dat[i] = '0; exp_cnt[i] = '0;
            exp_eadr[i] = '0; exp_sadr[i] = '0; exp_sdat[i] = '0;
        end
        repeat (3) step();
        rst_i = 1'b0;
        chk_on = 1;

        a0 = n_ack;
        txn(8'h35, 1'b0, 8'h00, 0, 8'hA5, 0, 0);
        chk("t1_ack_pulses", 32'(n_ack - a0), 32'd1);
        chk("t1_rdata", 32'(snap_mdat), 32'hA5);

        t3c0 = cyc + 1;
        d4_on = 1;
        txn(8'h07, 1'b0, 8'h00, -1, 8'h00, 0, 0);
        d4_on = 0;
        chk("t3_d4_stb_cycles", 32'(d4_stb), 32'd4);
        chk("t3_d4_err_pulses", 32'(d4_err), 32'd1);
        chk("t3_d4_err_cycle", 32'(d4_err_cyc - t3c0), 32'd5);
        chk("t3_d4_no_ack", 32'(d4_ack), 32'd0);
        chk("t3_d4_err_cnt", 32'(ecnt4), 32'd1);
        chk("t3_d4_err_adr", 32'(eadr4), 32'h07);
        chk("t3_err_cnt", 32'(err_cnt_o), 32'd1);
        chk("t3_err_adr", 32'(err_adr_o), 32'h07);

        a0 = n_ack;
        txn(8'hB2, 1'b1, 8'h5A, 7, 8'h77, 0, 0);
        chk("t2_ack_pulses", 32'(n_ack - a0), 32'd1);
        chk("t2_s_we", 32'(snap_we), 32'd1);
        chk("t2_s_adr", 32'(snap_sadr), 32'h2);
        chk("t2_s_dat", 32'(snap_sdat), 32'h5A);
        chk("t2_m_dat", 32'(snap_mdat), 32'h00);

        txn(8'hBF, 1'b0, 8'h00, 3, 8'h6D, 0, 0);
        chk("mux_slave11", 32'(snap_mdat), 32'h6D);

        a0 = n_ack; e0 = n_err;
        txn(8'h1C, 1'b0, 8'h00, TO - 1, 8'hD2, 0, 0);
        chk("t5_final_ack", 32'(n_ack - a0), 32'd1);
        chk("t5_final_no_err", 32'(n_err - e0), 32'd0);

        txn(8'h2A, 1'b0, 8'h00, TO, 8'hEE, 2, 0);

        a0 = n_ack; e0 = n_err;
        abandon(8'h93, 1);
        chk("t6_abandon_no_resp", 32'((n_ack - a0) + (n_err - e0)), 32'd0);

        a0 = n_ack;
        txn(8'h41, 1'b0, 8'h00, 1, 8'hC3, 4, 0);
        chk("t6_hold_one_txn", 32'(n_ack - a0), 32'd1);

        e0 = n_err;
        for (int i = 0; i < 300; i++)
            txn(8'hE0, 1'b0, 8'h00, -1, 8'h00, 0, 0);
        chk("t4_err_pulses", 32'(n_err - e0), 32'd300);
        chk("t4_saturated", 32'(err_cnt_o), 32'd255);
        chk("t4_err_adr", 32'(err_adr_o), 32'hE0);

        txn(8'hC5, 1'b0, 8'h00, -1, 8'h00, 0, 1);
        chk("t5_clr_with_err", 32'(err_cnt_o), 32'd1);
        chk("t5_clr_adr", 32'(err_adr_o), 32'hC5);

        do_clr();
        chk("clr_plain", 32'(err_cnt_o), 32'd0);
        chk("clr_keeps_adr", 32'(err_adr_o), 32'hC5);

        txn(8'hF1, 1'b0, 8'h00, -1, 8'h00, 0, 0);
        a0 = n_ack;
        rst_test(8'h62, 2);
        chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        chk("rst_err_adr", 32'(err_adr_o), 32'h00);
        chk("rst_ack_ignored", 32'(n_ack - a0), 32'd0);

        txn(8'h6B, 1'b0, 8'h00, 2, 8'h4F, 0, 0);
        chk("post_rst_read", 32'(snap_mdat), 32'h4F);

        step();
        chk("cycle_budget", 32'(cyc < N), 32'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
